// File: rtl/stage_decode.sv
// RV32I decode stage: owns the 32x32 register file, builds the immediate and
// control word, and registers everything into the execute pipeline register.
module stage_decode #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] de_instr,
    input  logic [31:0] de_pc,
    input  logic [31:0] de_pc_plus4,
    input  logic        ex_clear,
    input  logic        ex_stall,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic [4:0]  de_rs1,
    output logic [4:0]  de_rs2,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_pc_plus4,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic [3:0]  ex_alu_ctrl,
    output logic [1:0]  ex_alu_src_a,
    output logic        ex_alu_src_b,
    output logic [1:0]  ex_result_src,
    output logic        ex_reg_write,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_jalr,
    output logic        ex_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    logic [31:0] regs [31:1];
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  alu_ctrl, arith_ctrl;
    logic [1:0]  alu_src_a, result_src;
    logic        alu_src_b, reg_write, mem_write, branch, jump, jalr, illegal;

    assign opcode = de_instr[6:0];
    assign funct3 = de_instr[14:12];
    assign de_rs1 = de_instr[19:15];
    assign de_rs2 = de_instr[24:20];

    // x0 has no storage; reset clears the file and drops any concurrent writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (wb_reg_write && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_result;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (de_rs1 != 5'd0)
            rd1 = (wb_reg_write && wb_rd == de_rs1) ? wb_result : regs[de_rs1];
        if (de_rs2 != 5'd0)
            rd2 = (wb_reg_write && wb_rd == de_rs2) ? wb_result : regs[de_rs2];
    end

    // instr[30] selects SUB only for register-register ops, SRA/SRAI for both.
    always_comb begin
        arith_ctrl = ALU_ADD;
        case (funct3)
            3'b000: arith_ctrl = (opcode == OP_R && de_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001: arith_ctrl = ALU_SLL;
            3'b010: arith_ctrl = ALU_SLT;
            3'b011: arith_ctrl = ALU_SLTU;
            3'b100: arith_ctrl = ALU_XOR;
            3'b101: arith_ctrl = de_instr[30] ? ALU_SRA : ALU_SRL;
            3'b110: arith_ctrl = ALU_OR;
            3'b111: arith_ctrl = ALU_AND;
            default: arith_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        imm        = '0;
        alu_ctrl   = ALU_ADD;
        alu_src_a  = 2'd0;
        alu_src_b  = 1'b0;
        result_src = 2'd0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_ctrl  = arith_ctrl;
            end
            OP_IMM: begin
                imm       = {{20{de_instr[31]}}, de_instr[31:20]};
                reg_write = 1'b1;
                alu_src_b = 1'b1;
                alu_ctrl  = arith_ctrl;
            end
            OP_LOAD: begin
                imm        = {{20{de_instr[31]}}, de_instr[31:20]};
                reg_write  = 1'b1;
                result_src = 2'd1;
                alu_src_b  = 1'b1;
            end
            OP_STORE: begin
                imm       = {{20{de_instr[31]}}, de_instr[31:25], de_instr[11:7]};
                mem_write = 1'b1;
                alu_src_b = 1'b1;
            end
            OP_BRANCH: begin
                imm      = {{20{de_instr[31]}}, de_instr[7], de_instr[30:25], de_instr[11:8], 1'b0};
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                imm        = {{12{de_instr[31]}}, de_instr[19:12], de_instr[20], de_instr[30:21], 1'b0};
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'd2;
                alu_src_a  = 2'd1;
                alu_src_b  = 1'b1;
            end
            OP_JALR: begin
                imm        = {{20{de_instr[31]}}, de_instr[31:20]};
                jump       = 1'b1;
                jalr       = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'd2;
                alu_src_b  = 1'b1;
            end
            OP_LUI: begin
                imm       = {de_instr[31:12], 12'b0};
                reg_write = 1'b1;
                alu_src_a = 2'd2;
                alu_src_b = 1'b1;
            end
            OP_AUIPC: begin
                imm       = {de_instr[31:12], 12'b0};
                reg_write = 1'b1;
                alu_src_a = 2'd1;
                alu_src_b = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Reset and clear both produce a NOP bubble; only reset restores RESET_PC.
    always_ff @(posedge clk) begin
        if (!rst_n || ex_clear) begin
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_pc         <= rst_n ? 32'h0 : RESET_PC;
            ex_pc_plus4   <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_funct3     <= '0;
            ex_alu_ctrl   <= '0;
            ex_alu_src_a  <= '0;
            ex_alu_src_b  <= 1'b0;
            ex_result_src <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            ex_jalr       <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (!ex_stall) begin
            ex_rd1        <= rd1;
            ex_rd2        <= rd2;
            ex_imm        <= imm;
            ex_pc         <= de_pc;
            ex_pc_plus4   <= de_pc_plus4;
            ex_rs1        <= de_rs1;
            ex_rs2        <= de_rs2;
            ex_rd         <= de_instr[11:7];
            ex_funct3     <= funct3;
            ex_alu_ctrl   <= alu_ctrl;
            ex_alu_src_a  <= alu_src_a;
            ex_alu_src_b  <= alu_src_b;
            ex_result_src <= result_src;
            ex_reg_write  <= reg_write;
            ex_mem_write  <= mem_write;
            ex_branch     <= branch;
            ex_jump       <= jump;
            ex_jalr       <= jalr;
            ex_illegal    <= illegal;
        end
    end

endmodule

// File: tb/tb_stage_decode.sv
// Directed bench for stage_decode: a vector table for single-cycle decode plus
// hand sequences for reset, stall and clear.
module tb_stage_decode;

    localparam logic [31:0] RST_PC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] de_instr, de_pc, de_pc_plus4;
    logic        ex_clear, ex_stall, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [4:0]  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc, ex_pc_plus4;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_alu_ctrl;
    logic [1:0]  ex_alu_src_a, ex_result_src;
    logic        ex_alu_src_b, ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_jalr, ex_illegal;

    int errors = 0;
    int checks = 0;

    stage_decode #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .de_instr(de_instr), .de_pc(de_pc), .de_pc_plus4(de_pc_plus4),
        .ex_clear(ex_clear), .ex_stall(ex_stall), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_result(wb_result), .de_rs1(de_rs1), .de_rs2(de_rs2), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src_a(ex_alu_src_a),
        .ex_alu_src_b(ex_alu_src_b), .ex_result_src(ex_result_src), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // ctl packs {reg_write, mem_write, branch, jump, jalr, illegal}.
    typedef struct {
        logic [31:0] instr;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [1:0]  src_a;
        logic        src_b;
        logic [1:0]  res;
        logic [5:0]  ctl;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(logic [31:0] instr, logic we, logic [4:0] wrd, logic [31:0] wdata,
                                logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm, logic [4:0] rd,
                                logic [3:0] alu, logic [1:0] sa, logic sb, logic [1:0] res, logic [5:0] ctl);
        vec_t v;
        v.instr = instr; v.we = we; v.wrd = wrd; v.wdata = wdata;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.rd = rd;
        v.alu = alu; v.src_a = sa; v.src_b = sb; v.res = res; v.ctl = ctl;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic clr, input logic stl,
                                 input logic we, input logic [4:0] wrd, input logic [31:0] wdata);
        @(negedge clk);
        rst_n = rn; de_instr = instr; de_pc = pc; de_pc_plus4 = pc + 32'd4;
        ex_clear = clr; ex_stall = stl;
        wb_reg_write = we; wb_rd = wrd; wb_result = wdata;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ctlBits();
        return {ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_jalr, ex_illegal};
    endfunction

    task automatic checkBubble(input string tag, input logic [31:0] pc_exp);
        checkOutput({tag, " ctl"}, {26'd0, ctlBits()}, 32'd0);
        checkOutput({tag, " rd1"}, ex_rd1, 32'd0);
        checkOutput({tag, " rd2"}, ex_rd2, 32'd0);
        checkOutput({tag, " imm"}, ex_imm, 32'd0);
        checkOutput({tag, " pc"}, ex_pc, pc_exp);
        checkOutput({tag, " pc4"}, ex_pc_plus4, 32'd0);
        checkOutput({tag, " idx"}, {17'd0, ex_rs1, ex_rs2, ex_rd}, 32'd0);
        checkOutput({tag, " sel"}, {22'd0, ex_funct3, ex_alu_ctrl, ex_alu_src_a, ex_alu_src_b},
                    32'd0);
        checkOutput({tag, " res"}, {30'd0, ex_result_src}, 32'd0);
    endtask

    initial begin
        logic [31:0] pc;

        vecs[0]  = mk(32'h000283B3, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 7, 0, 0, 0, 0, 6'b100000);
        vecs[1]  = mk(32'hFFF00093, 1, 0, 32'h00001234, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 6'b100000);
        vecs[2]  = mk(32'h00028433, 0, 0, 0, 32'hDEADBEEF, 0, 0, 8, 0, 0, 0, 0, 6'b100000);
        vecs[3]  = mk(32'hFE208CE3, 1, 2, 32'h55, 0, 32'h55, 32'hFFFFFFF8, 25, 1, 0, 0, 0, 6'b001000);
        vecs[4]  = mk(32'h001000EF, 0, 0, 0, 0, 0, 32'h00000800, 1, 0, 1, 1, 2, 6'b100100);
        vecs[5]  = mk(32'hABCDE1B7, 0, 0, 0, 0, 0, 32'hABCDE000, 3, 0, 2, 1, 0, 6'b100000);
        vecs[6]  = mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 31, 0, 0, 0, 0, 6'b000001);
        vecs[7]  = mk(32'h00612623, 0, 0, 0, 32'h55, 0, 32'h0000000C, 12, 0, 0, 1, 0, 6'b010000);
        vecs[8]  = mk(32'h402084B3, 1, 1, 32'h100, 32'h100, 32'h55, 0, 9, 1, 0, 0, 0, 6'b100000);
        vecs[9]  = mk(32'h4030D513, 0, 0, 0, 32'h100, 0, 32'h00000403, 10, 7, 0, 1, 0, 6'b100000);
        vecs[10] = mk(32'h40008593, 0, 0, 0, 32'h100, 0, 32'h00000400, 11, 0, 0, 1, 0, 6'b100000);
        vecs[11] = mk(32'hFFC0A603, 0, 0, 0, 32'h100, 0, 32'hFFFFFFFC, 12, 0, 0, 1, 1, 6'b100000);
        vecs[12] = mk(32'h008100E7, 0, 0, 0, 32'h55, 0, 32'h00000008, 1, 0, 0, 1, 2, 6'b100110);
        vecs[13] = mk(32'h12345297, 0, 0, 0, 0, 0, 32'h12345000, 5, 0, 1, 1, 0, 6'b100000);
        vecs[14] = mk(32'h0020E6B3, 0, 0, 0, 32'h100, 32'h55, 0, 13, 3, 0, 0, 0, 6'b100000);
        vecs[15] = mk(32'h0050B713, 0, 0, 0, 32'h100, 32'hDEADBEEF, 32'h00000005, 14, 9, 0, 1, 0, 6'b100000);

        // Reset with junk inputs, including a writeback that must be dropped.
        applyStimulus(0, 32'h000283B3, 32'h40, 1, 0, 1, 5, 32'h0BAD);
        stepEdge();
        applyStimulus(0, 32'hFFFFFFFF, 32'h44, 0, 1, 1, 6, 32'h0BAD);
        stepEdge();
        checkBubble("reset1", RST_PC);

        // Store a value in x5, then reset again and confirm it is wiped.
        applyStimulus(1, 32'h00000013, 32'h0, 0, 0, 1, 5, 32'h0000CAFE);
        stepEdge();
        applyStimulus(0, 32'h000283B3, 32'h0, 0, 0, 1, 5, 32'h0000BEEF);
        stepEdge();
        applyStimulus(0, 32'h000283B3, 32'h0, 0, 0, 0, 0, 32'h0);
        stepEdge();
        checkBubble("reset2", RST_PC);
        applyStimulus(1, 32'h000283B3, 32'h80, 0, 0, 0, 0, 32'h0);
        stepEdge();
        checkOutput("x5 after reset", ex_rd1, 32'd0);
        checkOutput("x5 read rd", {27'd0, ex_rd}, 32'd7);

        for (int i = 0; i < 16; i++) begin
            pc = 32'h100 + 32'(i) * 32'd4;
            applyStimulus(1, vecs[i].instr, pc, 0, 0, vecs[i].we, vecs[i].wrd, vecs[i].wdata);
            #1;
            checkOutput($sformatf("v%0d de_rs1", i), {27'd0, de_rs1}, {27'd0, vecs[i].instr[19:15]});
            checkOutput($sformatf("v%0d de_rs2", i), {27'd0, de_rs2}, {27'd0, vecs[i].instr[24:20]});
            stepEdge();
            checkOutput($sformatf("v%0d rd1", i), ex_rd1, vecs[i].rd1);
            checkOutput($sformatf("v%0d rd2", i), ex_rd2, vecs[i].rd2);
            checkOutput($sformatf("v%0d imm", i), ex_imm, vecs[i].imm);
            checkOutput($sformatf("v%0d rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
            checkOutput($sformatf("v%0d rs1", i), {27'd0, ex_rs1}, {27'd0, vecs[i].instr[19:15]});
            checkOutput($sformatf("v%0d rs2", i), {27'd0, ex_rs2}, {27'd0, vecs[i].instr[24:20]});
            checkOutput($sformatf("v%0d funct3", i), {29'd0, ex_funct3}, {29'd0, vecs[i].instr[14:12]});
            checkOutput($sformatf("v%0d alu_ctrl", i), {28'd0, ex_alu_ctrl}, {28'd0, vecs[i].alu});
            checkOutput($sformatf("v%0d src_a", i), {30'd0, ex_alu_src_a}, {30'd0, vecs[i].src_a});
            checkOutput($sformatf("v%0d src_b", i), {31'd0, ex_alu_src_b}, {31'd0, vecs[i].src_b});
            checkOutput($sformatf("v%0d result_src", i), {30'd0, ex_result_src}, {30'd0, vecs[i].res});
            checkOutput($sformatf("v%0d ctl", i), {26'd0, ctlBits()}, {26'd0, vecs[i].ctl});
            checkOutput($sformatf("v%0d pc", i), ex_pc, pc);
            checkOutput($sformatf("v%0d pc4", i), ex_pc_plus4, pc + 32'd4);
        end

        // Stall: sw x6,12(x2) is held for 3 cycles while x2 is rewritten underneath.
        applyStimulus(1, 32'h00612623, 32'h300, 0, 0, 0, 0, 32'h0);
        stepEdge();
        checkOutput("sw mem_write", {31'd0, ex_mem_write}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 32'hABCDE1B7, 32'h400, 0, 1, (c == 0), 2, 32'h77);
            stepEdge();
            checkOutput($sformatf("stall%0d ctl", c), {26'd0, ctlBits()}, {26'd0, 6'b010000});
            checkOutput($sformatf("stall%0d rd1", c), ex_rd1, 32'h55);
            checkOutput($sformatf("stall%0d imm", c), ex_imm, 32'h0000000C);
            checkOutput($sformatf("stall%0d pc", c), ex_pc, 32'h300);
            checkOutput($sformatf("stall%0d src", c), {22'd0, ex_alu_src_a, ex_alu_src_b, ex_rd, 1'b0},
                        {22'd0, 2'd0, 1'b1, 5'd12, 1'b0});
        end
        applyStimulus(1, 32'h00612623, 32'h304, 0, 0, 0, 0, 32'h0);
        stepEdge();
        checkOutput("post-stall x2", ex_rd1, 32'h77);
        checkOutput("post-stall pc", ex_pc, 32'h304);

        // Clear together with stall must still insert a bubble with ex_pc = 0.
        applyStimulus(1, 32'h000283B3, 32'h500, 0, 0, 0, 0, 32'h0);
        stepEdge();
        checkOutput("pre-clear reg_write", {31'd0, ex_reg_write}, 32'd1);
        applyStimulus(1, 32'h000283B3, 32'h504, 1, 1, 0, 0, 32'h0);
        stepEdge();
        checkBubble("clear+stall", 32'h0);
        applyStimulus(1, 32'h001000EF, 32'h508, 1, 0, 0, 0, 32'h0);
        stepEdge();
        checkBubble("clear", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_decode.md
# stage_decode

Decode stage of the 5-stage RV32I core. Consumes `de_instr`, `de_pc` and `de_pc_plus4` from instruction fetch, reads the 32×32 register file (which it owns), generates the immediate and control word, and registers everything into the execute pipeline register. The register file write port is driven by writeback. The hazard unit drives `ex_clear` and `ex_stall`.

## Interface
Parameters:
- `RESET_PC`, 32'h0: value loaded into `ex_pc` on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `de_instr`  in  32  instruction from fetch/ROM.
- `de_pc`, `de_pc_plus4`  in  32  PC and PC+4 of `de_instr`.
- `ex_clear`  in  1  flush the execute register (insert a bubble).
- `ex_stall`  in  1  hold the execute register.
- `wb_reg_write`  in  1  register file write enable.
- `wb_rd`  in  5  write address.
- `wb_result`  in  32  write data.
- `de_rs1`, `de_rs2`  out  5  combinational `instr[19:15]` and `instr[24:20]`, to the hazard unit.
- `ex_rd1`, `ex_rd2`, `ex_imm`, `ex_pc`, `ex_pc_plus4`  out  32  registered operands.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5  registered register indices.
- `ex_funct3`  out  3  registered; the branch comparator uses it.
- `ex_alu_ctrl`  out  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- `ex_alu_src_a`  out  2  operand A select: 0=rd1, 1=pc, 2=zero.
- `ex_alu_src_b`  out  1  operand B select: 0=rd2, 1=imm.
- `ex_result_src`  out  2  result select: 0=ALU, 1=memory, 2=pc+4.
- `ex_reg_write`, `ex_mem_write`, `ex_branch`, `ex_jump`, `ex_jalr`, `ex_illegal`  out  1  registered control bits.

## Operation
- **Register file**
  - x0 always reads 0. Writes to x0 are ignored.
  - Reads are combinational.
  - Write-through: if `wb_reg_write` is high, `wb_rd` is nonzero and `wb_rd` equals rs1 (or rs2), the corresponding read returns `wb_result` in the same cycle.
  - The file is written on the rising edge.
  - Writes happen regardless of `ex_stall` and `ex_clear`.
- **Immediate generation**, by opcode, sign-extended:
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- **Opcode decode**:
  - OP 0110011: reg_write; src_b=rd2; alu_ctrl from funct3/funct7[5].
  - OP-IMM 0010011: as OP with src_b=imm. funct7[5] is used only for shift-right (SRAI).
  - LOAD 0000011: reg_write, result_src=1, ADD, imm.
  - STORE 0100011: mem_write, ADD, imm.
  - BRANCH 1100011: branch, SUB, src_b=rd2.
  - JAL 1101111: jump, reg_write, result_src=2, src_a=pc, imm.
  - JALR 1100111: jump, jalr, reg_write, result_src=2, src_a=rd1, imm.
  - LUI 0110111: reg_write, src_a=zero, imm, ADD.
  - AUIPC 0010111: reg_write, src_a=pc, imm, ADD.
  - Any other opcode: all write/branch/jump bits 0, `ex_illegal`=1.
- **Execute register update priority**: `!rst_n` > `ex_clear` > `!ex_stall`. When `ex_stall` is high and `ex_clear` is low, all ex_* outputs hold.
- **Clear/bubble value**: every control bit 0, all data fields 0, `ex_pc`=0. This equals a NOP.

## Timing
- **Latency**: a decode input sampled at edge N appears on ex_* after edge N. Decode-to-execute latency is 1 cycle.
- **Reset**: reset is applied at the edge where `rst_n`=0 is sampled. After it:
  - all ex_* outputs are 0, except `ex_pc`=`RESET_PC`;
  - x1..x31 are cleared to 0.
- **Reset mid-operation**: reset overrides stall, clear and writeback. A writeback write in the reset cycle is dropped.
- **`ex_clear` with `ex_stall`**: when both are high, the clear wins.
- **Writeback during stall**: the file updates. The held `ex_rd1`/`ex_rd2` do not refresh. Forwarding those held values is the hazard unit's concern.
- `de_rs1`/`de_rs2` are purely combinational with no register.

## Test plan
- **Reset**: hold `rst_n`=0 for 2 cycles with arbitrary inputs. Required:
  - all ex_* are 0 and `ex_pc`=`RESET_PC`;
  - a subsequent read of x5 returns 0.
- **Write-through**: apply `wb_reg_write`=1, `wb_rd`=5, `wb_result`=32'hDEADBEEF in the same cycle as `de_instr`=`add x7,x5,x0` (32'h000283B3). Required next cycle:
  - `ex_rd1`=32'hDEADBEEF, `ex_rd2`=0, `ex_rd`=7;
  - `ex_alu_ctrl`=0, `ex_reg_write`=1.
- **x0 write ignored**: write 32'h1234 to x0, then decode `addi x1,x0,-1` (32'hFFF00093). Required:
  - `ex_rd1`=0, `ex_imm`=32'hFFFFFFFF, `ex_alu_src_b`=1.
- **Immediates**:
  - `beq x1,x2,-8` (32'hFE208CE3): `ex_imm`=32'hFFFFFFF8, `ex_branch`=1, `ex_alu_ctrl`=1.
  - `jal x1,2048` (32'h001000EF): `ex_imm`=32'h00000800, `ex_result_src`=2, `ex_jump`=1.
  - `lui x3,0xABCDE` (32'hABCDE1B7): `ex_imm`=32'hABCDE000, `ex_alu_src_a`=2.
- **Stall and clear**:
  - Decode `sw` while `ex_stall`=1 for 3 cycles: ex_* stays unchanged.
  - Raise `ex_clear` and `ex_stall` together: next cycle all control bits are 0.
- **Illegal**: `de_instr`=32'hFFFFFFFF. Required: `ex_illegal`=1 and `ex_reg_write`=`ex_mem_write`=`ex_branch`=`ex_jump`=0.
